rs_dispatch_arbiter: RTL and testbench

//  Shares one functional unit (FU) between NUM_RS reservation stations in the Tomasulo datapath.

---
 rtl/rs_dispatch_arbiter.sv | 140 ++++++++++++++
 tb/tb_rs_dispatch_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dispatch_arbiter.sv
// ============================================================================
// rs_dispatch_arbiter : shares one FU among NUM_RS reservation stations and
// broadcasts the result on the CDB. Optional macro: ROUND_ROBIN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_dispatch_arbiter #(
  parameter int NUM_RS   = 3,
  parameter int DATA_W   = 16,
  parameter int OP_W     = 3,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_RS-1:0]        req,
  input  logic [NUM_RS*OP_W-1:0]   rs_op,
  input  logic [NUM_RS*DATA_W-1:0] rs_vj,
  input  logic [NUM_RS*DATA_W-1:0] rs_vk,
  output logic [NUM_RS-1:0]        grant,
  output logic                     fu_start,
  output logic [OP_W-1:0]          fu_op,
  output logic [DATA_W-1:0]        fu_a,
  output logic [DATA_W-1:0]        fu_b,
  input  logic                     fu_done,
  input  logic [DATA_W-1:0]        fu_result,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  input  logic                     cdb_ack,
  output logic                     busy
);

  localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    BCAST = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] sel;
  logic [IW-1:0] win;
  logic          found;
  logic          take;

`ifdef ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
  logic [IW:0]   cand;

  // Cyclic search starting at the pointer; cand never exceeds 2*NUM_RS-2.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_RS)) cand = cand - (IW+1)'(NUM_RS);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (win == IW'(NUM_RS-1)) ? '0 : win + 1'b1;
    end
  end
`else
  always_comb begin
    win   = '0;
    found = |req;
    for (int k = NUM_RS-1; k >= 0; k--) begin
      if (req[k]) win = IW'(k);
    end
  end
`endif

  assign take = (state == IDLE) && !flush && found;

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (found)   state_nx = ISSUE;
        ISSUE:                state_nx = WAIT;
        WAIT:    if (fu_done) state_nx = BCAST;
        BCAST:   if (cdb_ack) state_nx = IDLE;
        default:              state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      fu_op    <= '0;
      fu_a     <= '0;
      fu_b     <= '0;
      cdb_tag  <= '0;
      cdb_data <= '0;
    end else begin
      if (take) begin
        sel     <= win;
        fu_op   <= rs_op[win*OP_W +: OP_W];
        fu_a    <= rs_vj[win*DATA_W +: DATA_W];
        fu_b    <= rs_vk[win*DATA_W +: DATA_W];
        cdb_tag <= TAG_W'(TAG_BASE + int'(win));
      end
      if (state == WAIT && fu_done && !flush) cdb_data <= fu_result;
    end
  end

  always_comb begin
    grant = '0;
    if (state == ISSUE) grant[sel] = 1'b1;
  end

  assign fu_start  = (state == ISSUE);
  assign cdb_valid = (state == BCAST);
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rs_dispatch_arbiter.sv
// Randomized and directed bench for rs_dispatch_arbiter against a transaction-level model.
`default_nettype none

module tb_rs_dispatch_arbiter;
  localparam int NUM_RS = 3, DATA_W = 16, OP_W = 3, TAG_W = 3, TAG_BASE = 1;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [NUM_RS-1:0]        req = '0;
  logic [NUM_RS*OP_W-1:0]   rs_op = '0;
  logic [NUM_RS*DATA_W-1:0] rs_vj = '0, rs_vk = '0;
  logic [NUM_RS-1:0]        grant;
  logic                     fu_start, fu_done = 1'b0, cdb_valid, cdb_ack = 1'b0, busy;
  logic [OP_W-1:0]          fu_op;
  logic [DATA_W-1:0]        fu_a, fu_b, fu_result = '0, cdb_data;
  logic [TAG_W-1:0]         cdb_tag;

  rs_dispatch_arbiter #(.NUM_RS(NUM_RS), .DATA_W(DATA_W), .OP_W(OP_W),
                        .TAG_W(TAG_W), .TAG_BASE(TAG_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .rs_op(rs_op),
    .rs_vj(rs_vj), .rs_vk(rs_vk), .grant(grant), .fu_start(fu_start),
    .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_done(fu_done),
    .fu_result(fu_result), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_ack(cdb_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: an operation is either absent, being issued, awaiting the FU, or on the CDB.
  typedef enum int {M_NONE, M_ISSUE, M_WAIT, M_BCAST} mphase_t;
  mphase_t m_phase = M_NONE;
  int      m_ptr = 0, m_win = 0;
  logic [OP_W-1:0]   m_op = '0;
  logic [DATA_W-1:0] m_a = '0, m_b = '0, m_data = '0;
  logic [TAG_W-1:0]  m_tag = '0;

  function automatic int pick(input logic [NUM_RS-1:0] r, input int start);
    for (int k = 0; k < NUM_RS; k++) begin
      int i;
      i = (start + k) % NUM_RS;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = M_NONE; m_ptr = 0; m_win = 0;
    m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_tag = '0;
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      m_phase = M_NONE;
    end else begin
      case (m_phase)
        M_NONE: begin
`ifdef ROUND_ROBIN_EN
          w = pick(req, m_ptr);
`else
          w = pick(req, 0);
`endif
          if (w >= 0) begin
            m_win = w;
            m_op  = rs_op[w*OP_W +: OP_W];
            m_a   = rs_vj[w*DATA_W +: DATA_W];
            m_b   = rs_vk[w*DATA_W +: DATA_W];
            m_tag = TAG_W'(TAG_BASE + w);
            m_ptr = (w + 1) % NUM_RS;
            m_phase = M_ISSUE;
          end
        end
        M_ISSUE: m_phase = M_WAIT;
        M_WAIT:  if (fu_done) begin m_data = fu_result; m_phase = M_BCAST; end
        M_BCAST: if (cdb_ack) m_phase = M_NONE;
        default: m_phase = M_NONE;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("grant", 32'(grant), (m_phase == M_ISSUE) ? 32'(1 << m_win) : 32'd0);
    check_eq("fu_start", 32'(fu_start), 32'(m_phase == M_ISSUE));
    check_eq("fu_op", 32'(fu_op), 32'(m_op));
    check_eq("fu_a", 32'(fu_a), 32'(m_a));
    check_eq("fu_b", 32'(fu_b), 32'(m_b));
    check_eq("cdb_valid", 32'(cdb_valid), 32'(m_phase == M_BCAST));
    check_eq("busy", 32'(busy), 32'(m_phase != M_NONE));
    if (m_phase == M_BCAST) begin
      check_eq("cdb_tag", 32'(cdb_tag), 32'(m_tag));
      check_eq("cdb_data", 32'(cdb_data), 32'(m_data));
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    compare_all();
  endtask

  task automatic idle_inputs();
    req = '0; flush = 1'b0; fu_done = 1'b0; cdb_ack = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    cdb_ack = 1'b1; fu_done = 1'b1;
    for (int i = 0; i < 6; i++) step();
    idle_inputs();
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out"}, 32'({grant, fu_start, cdb_valid, busy}), 32'd0);
    check_eq({tag, "_fu"}, 32'({fu_op, fu_a, fu_b}), 32'd0);
    check_eq({tag, "_cdb"}, 32'({cdb_tag, cdb_data}), 32'd0);
  endtask

  logic [NUM_RS-1:0] gq[$];
  logic [NUM_RS-1:0] exp_order [3];

  initial begin
    // Reset state
    #12;
    check_all_zero("reset_hold");
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Contention: three back-to-back operations with every station requesting
    req = 3'b111; fu_done = 1'b1; cdb_ack = 1'b1;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_op[i*OP_W +: OP_W] = OP_W'(i + 1);
      rs_vj[i*DATA_W +: DATA_W] = DATA_W'(16'h100 + i);
      rs_vk[i*DATA_W +: DATA_W] = DATA_W'(16'h200 + i);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      if (grant != '0) gq.push_back(grant);
    end
`ifdef ROUND_ROBIN_EN
    exp_order = '{3'b001, 3'b010, 3'b100};
`else
    exp_order = '{3'b001, 3'b001, 3'b001};
`endif
    check_eq("contention_cnt", 32'(gq.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < gq.size(); i++)
      check_eq("contention_order", 32'(gq[i]), 32'(exp_order[i]));
    drain();

    // Single operation with a CDB stall
    rs_op[1*OP_W +: OP_W] = 3'd2;
    rs_vj[1*DATA_W +: DATA_W] = 16'h0005;
    rs_vk[1*DATA_W +: DATA_W] = 16'h0003;
    req = 3'b010;
    step();
    check_eq("single_grant", 32'(grant), 32'h2);
    check_eq("single_start", 32'(fu_start), 32'd1);
    req = 3'b000;
    step();
    check_eq("single_start_pulse", 32'(fu_start), 32'd0);
    step();
    fu_done = 1'b1; fu_result = 16'h0008;
    step();
    fu_done = 1'b0; fu_result = 16'hdead;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_valid", 32'(cdb_valid), 32'd1);
      check_eq("stall_tag", 32'(cdb_tag), 32'd2);
      check_eq("stall_data", 32'(cdb_data), 32'h0008);
    end
    cdb_ack = 1'b1;
    step();
    check_eq("ack_drop", 32'(cdb_valid), 32'd0);
    cdb_ack = 1'b0;
    step();

    // Flush during WAIT beats a simultaneous fu_done
    req = 3'b001; step();
    req = 3'b000; step();
    flush = 1'b1; fu_done = 1'b1; fu_result = 16'h1234; step();
    flush = 1'b0; step(); step();
    check_eq("flush_valid", 32'(cdb_valid), 32'd0);
    check_eq("flush_busy", 32'(busy), 32'd0);
    fu_done = 1'b0;
    req = 3'b100; step();
    check_eq("post_flush_grant", 32'(grant), 32'h4);
    drain();

    // Asynchronous reset while broadcasting
    req = 3'b001; fu_done = 1'b1; step(); req = 3'b000;
    step(); step();
    check_eq("pre_reset_bcast", 32'(cdb_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic, including spurious fu_done and occasional flush
    for (int i = 0; i < 3000; i++) begin
      req       = NUM_RS'($urandom);
      rs_op     = (NUM_RS*OP_W)'($urandom);
      rs_vj     = {$urandom, $urandom};
      rs_vk     = {$urandom, $urandom};
      fu_done   = ($urandom_range(0, 2) == 0);
      fu_result = DATA_W'($urandom);
      cdb_ack   = ($urandom_range(0, 1) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
